countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Param DIGITS, default 4, number of cascaded digits (1..8).
REQ-002 Param MOD_VEC, default 16'h6A6A, packed 4-bit modulus per digit, digit i = MOD_VEC[4i+3:4i], each 2..10; default is mm:ss.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 CLR  in  1  reset, synchronous, active-high.
REQ-005 CE  in  1  count tick enable (e.g. 1 Hz strobe), one CLK cycle wide.
REQ-006 LOAD  in  1  load LOAD_VAL into Q and reload register.
REQ-007 LOAD_VAL  in  4*DIGITS  packed digit values, digit 0 in LSBs.
REQ-008 START  in  1  begin/resume counting.
REQ-009 STOP  in  1  pause counting.
REQ-010 Q  out  4*DIGITS  current count, packed as LOAD_VAL.
REQ-011 RUN  out  1  high in RUNNING state.
REQ-012 ZERO  out  1  high when every digit of Q is 0 (combinational from Q).
REQ-013 DONE  out  1  registered one-cycle pulse on expiry.
REQ-014 CEO  out  1  CE & RUN & ZERO, cascade carry.

Function
REQ-015 States: IDLE, RUNNING, PAUSED, EXPIRED; input priority per cycle SHALL be CLR > LOAD > STOP > START > CE.
REQ-016 LOAD from any state: Q and reload register <= LOAD_VAL, each digit saturated to modulus-1 if out of range; state -> IDLE; DONE 0.
REQ-017 START in IDLE or PAUSED with ZERO=0 -> RUNNING next cycle; START with ZERO=1, or in RUNNING/EXPIRED, SHALL be ignored.
REQ-018 STOP in RUNNING -> PAUSED, Q held; STOP in other states ignored.
REQ-019 In RUNNING with CE=1, digit i SHALL decrement iff all digits below i are 0; a digit at 0 that decrements wraps to its modulus-1 (borrow chain), single-cycle, no latency beyond one CLK.
REQ-020 CE outside RUNNING SHALL not change Q.
REQ-021 Expiry: CE in RUNNING with Q==1 (digit0=1, others 0) -> Q=0 and DONE=1 in the following cycle, exactly one cycle wide.
REQ-022 After expiry without COUNTDOWN_AUTO_RELOAD_EN: state -> EXPIRED, Q holds 0 until LOAD or CLR.
REQ-023 CE and STOP in same cycle: STOP wins, no decrement.
REQ-024 CE and LOAD in same cycle: LOAD wins, loaded value not decremented.

Reset
REQ-025 CLR=1 at a CLK edge: Q <= 0, reload register <= 0, state -> IDLE, RUN=0, DONE=0; ZERO=1, CEO=0.
REQ-026 CLR mid-count SHALL abort immediately with no DONE pulse; CLR overrides all other inputs.

Configuration
REQ-027 Macro COUNTDOWN_AUTO_RELOAD_EN defined: on expiry state stays RUNNING, DONE still pulses, and the next CE with Q==0 loads the reload register (period = reload value + 1 ticks); a reload register of 0 SHALL force EXPIRED instead.
REQ-028 Macro undefined: reload register and reload path absent; behaviour per REQ-022.

Structure
REQ-029 Shared package countdown_pkg SHALL hold state encoding constants (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, EXPIRED=2'd3) and digit width constant DIGIT_W=4.
REQ-030 One sub-module countdown_digit (parameter MODULO; ports CLK, CLR, LD, D, DEC, Q, BORROW), instantiated DIGITS times via generate; FSM, saturation and expiry logic in the top.

Verification
REQ-031 Defaults, LOAD 16'h0105 (01:05), START, 6 CE -> Q steps 0104,0103,0102,0101,0100,0059 (01:04 .. 00:59).
REQ-032 LOAD 16'h0002, START, 2 CE -> Q=0000, DONE high exactly one cycle, state EXPIRED; further CE/START leave Q=0000.
REQ-033 LOAD 16'h0030, START, CE, STOP+CE same cycle, 3 CE, START, CE -> Q 0029, 0029, 0029, 0028.
REQ-034 LOAD 16'hF9F9 -> Q=5959 (saturated); CLR during RUNNING -> next cycle Q=0000, RUN=0, no DONE.
REQ-035 COUNTDOWN_AUTO_RELOAD_EN defined, LOAD 16'h0002, START, 6 CE -> Q 0001,0000,0002,0001,0000,0002; DONE pulses twice, RUN stays 1.

Source files
------------

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding, digit width and load saturation helper
package countdown_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Clamp an out-of-range digit value to the largest legal value for its modulus.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v,
                                                    input logic [DIGIT_W-1:0] m);
    return (v >= m) ? m - 4'd1 : v;
  endfunction

endpackage

// File: rtl/countdown_digit.sv
// rtl/countdown_digit.sv - one modulo-N down-counting digit with load and borrow-out
module countdown_digit
  import countdown_pkg::*;
#(
  parameter int MODULO = 10
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               LD,
  input  logic [DIGIT_W-1:0] D,
  input  logic               DEC,
  output logic [DIGIT_W-1:0] Q,
  output logic               BORROW
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULO - 1);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      Q <= '0;
    end else if (LD) begin
      Q <= D;
    end else if (DEC) begin
      Q <= (Q == '0) ? TOP : Q - 4'd1;
    end
  end

  // A digit at zero passes the decrement on to the next digit up.
  assign BORROW = (Q == '0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - cascaded-digit countdown timer FSM; COUNTDOWN_AUTO_RELOAD_EN enables periodic reload
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int                     DIGITS  = 4,
  parameter logic [4*DIGITS-1:0]    MOD_VEC = 16'h6A6A
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] LOAD_VAL,
  input  logic                START,
  input  logic                STOP,
  output logic [4*DIGITS-1:0] Q,
  output logic                RUN,
  output logic                ZERO,
  output logic                DONE,
  output logic                CEO
);

  state_t                state;
  logic [4*DIGITS-1:0]   sat_val;
  logic [4*DIGITS-1:0]   d_val;
  logic [DIGITS-1:0]     dec;
  logic [DIGITS-1:0]     borrow;
  logic                  is_one;
  logic                  count_en;
  logic                  tick;
  logic                  reload_fire;
  logic                  zero_expire;
  logic                  digit_ld;

  assign ZERO     = &borrow;
  assign is_one   = (Q == (4*DIGITS)'(1));
  assign RUN      = (state == RUNNING);
  assign CEO      = CE & RUN & ZERO;
  // CE only counts when no higher-priority input is present this cycle.
  assign count_en = CE & RUN & ~STOP & ~LOAD & ~CLR;
  assign tick     = count_en & ~ZERO;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [4*DIGITS-1:0] reload_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      reload_q <= '0;
    end else if (LOAD) begin
      reload_q <= sat_val;
    end
  end

  assign reload_fire = count_en & ZERO & (reload_q != '0);
  assign zero_expire = count_en & ZERO & (reload_q == '0);
  assign d_val       = LOAD ? sat_val : reload_q;
`else
  assign reload_fire = 1'b0;
  assign zero_expire = 1'b0;
  assign d_val       = sat_val;
`endif

  assign digit_ld = LOAD | reload_fire;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      localparam logic [DIGIT_W-1:0] MODI = MOD_VEC[4*i +: 4];

      assign sat_val[4*i +: 4] = sat_digit(LOAD_VAL[4*i +: 4], MODI);

      if (i == 0) begin : g_first
        assign dec[i] = tick;
      end else begin : g_rest
        assign dec[i] = dec[i-1] & borrow[i-1];
      end

      countdown_digit #(.MODULO(int'(MODI))) u_digit (
        .CLK    (CLK),
        .CLR    (CLR),
        .LD     (digit_ld),
        .D      (d_val[4*i +: 4]),
        .DEC    (dec[i]),
        .Q      (Q[4*i +: 4]),
        .BORROW (borrow[i])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      DONE  <= 1'b0;
    end else if (LOAD) begin
      state <= IDLE;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (STOP) begin
        if (state == RUNNING) state <= PAUSED;
      end else if (START && (state == IDLE || state == PAUSED) && !ZERO) begin
        state <= RUNNING;
      end else if (tick && is_one) begin
        DONE <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        state <= EXPIRED;
`endif
      end else if (zero_expire) begin
        state <= EXPIRED;
      end
    end
  end

endmodule
